// File: rtl/itof_pipe.sv
// itof_pipe: three-stage signed int32 to IEEE-754 single converter.
// Stages: magnitude capture, normalize, round/pack; valid/ready flow.
module itof_pipe (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_x,
    input  logic        in_rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_y,
    output logic        busy
);

    typedef struct packed {
        logic        sign;
        logic        rm;
        logic [31:0] mag;
    } s1_t;

    typedef struct packed {
        logic        sign;
        logic        rm;
        logic        zero;
        logic [4:0]  lz;
        logic [31:0] norm;
    } s2_t;

    logic        v1, v2, v3;
    logic        e1, e2, e3;
    s1_t         s1_q, s1_d;
    s2_t         s2_q, s2_d;
    logic [31:0] y_q, y_d;
    logic        found;
    logic [22:0] frac;
    logic        g, st, l, inc;
    logic [23:0] sum;
    logic [7:0]  exp_v;

    // Enable chain: a stage may load when empty or when its successor moves.
    always_comb begin
        e3        = ~v3 | out_ready;
        e2        = ~v2 | e3;
        e1        = ~v1 | e2;
        in_ready  = e1 & rstn;
        out_valid = v3;
        out_y     = y_q;
        busy      = v1 | v2 | v3;
    end

    // S1 next: sign and absolute value (0x80000000 maps to 2^31).
    always_comb begin
        s1_d      = '0;
        s1_d.sign = in_x[31];
        s1_d.rm   = in_rm;
        s1_d.mag  = in_x[31] ? (~in_x + 32'd1) : in_x;
    end

    // S2 next: leading-zero count and left-justified magnitude.
    always_comb begin
        s2_d      = '0;
        found     = 1'b0;
        s2_d.sign = s1_q.sign;
        s2_d.rm   = s1_q.rm;
        for (int i = 31; i >= 0; i--) begin
            if (!found && s1_q.mag[i]) begin
                s2_d.lz = 5'(31 - i);
                found   = 1'b1;
            end
        end
        s2_d.zero = ~found;
        s2_d.norm = s1_q.mag << s2_d.lz;
    end

    // S3 next: round (nearest-even or truncate) and pack the word.
    always_comb begin
        frac  = s2_q.norm[30:8];
        g     = s2_q.norm[7];
        st    = |s2_q.norm[6:0];
        l     = s2_q.norm[8];
        inc   = s2_q.rm & g & (st | l);
        sum   = {1'b0, frac} + {23'd0, inc};
        exp_v = 8'd158 - {3'd0, s2_q.lz} + {7'd0, sum[23]};
        y_d   = s2_q.zero ? 32'd0 : {s2_q.sign, exp_v, sum[22:0]};
    end

    // Pipeline registers: each stage loads from upstream when enabled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
            y_q  <= '0;
        end else begin
            if (e1) begin
                v1   <= in_valid;
                s1_q <= s1_d;
            end
            if (e2) begin
                v2   <= v1;
                s2_q <= s2_d;
            end
            if (e3) begin
                v3  <= v2;
                y_q <= y_d;
            end
        end
    end

endmodule

// File: tb/tb_itof_pipe.sv
// tb_itof_pipe: scoreboard bench for itof_pipe.
// Driver pushes expected words; a negedge monitor pops and compares.
module tb_itof_pipe;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x;
    logic        in_rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;
    logic        busy;

    typedef struct {
        logic [31:0] y;
        int          acyc;
        bit          lat;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          lat_chk = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_y = '0;

    itof_pipe dut (
        .clk(clk),
        .rstn(rstn),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_x(in_x),
        .in_rm(in_rm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_y(out_y),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: value = mag * 2^0, keep 24 significant bits, round
    // the discarded remainder against one half ulp.
    function automatic logic [31:0] ref_model(input logic [31:0] x,
                                              input bit rm);
        longint m, qv, rem, half;
        int     e, sh;
        m = longint'($signed(x));
        if (m < 0) m = -m;
        if (m == 0) return 32'd0;
        e = 0;
        while ((m >> (e + 1)) != 0) e++;
        rem = 0;
        half = 1;
        if (e <= 23) begin
            qv = m << (23 - e);
        end else begin
            sh   = e - 23;
            qv   = m >> sh;
            rem  = m - (qv << sh);
            half = longint'(1) << (sh - 1);
            if (rm && (rem > half || (rem == half && qv[0])))
                qv++;
        end
        if (qv == (longint'(1) << 24)) begin
            qv = qv >> 1;
            e++;
        end
        return {x[31], 8'(e + 127), qv[22:0]};
    endfunction

    // Monitor: pop on every output transfer; watch stalled outputs.
    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_y", out_y, prev_y);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %h expected none",
                             out_y);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("result", out_y, e.y);
                    if (e.lat)
                        chk("latency", 32'(cyc - e.acyc), 32'd3);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_y     = out_y;
        end
    end

    task automatic step(input bit v, input logic [31:0] x, input bit rm,
                        input bit ordy, output bit acc);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_x      = x;
        in_rm     = rm;
        out_ready = ordy;
        @(negedge clk);
        acc = v && in_ready;
        if (acc) begin
            e.y    = ref_model(x, rm);
            e.acyc = cyc;
            e.lat  = lat_chk;
            q.push_back(e);
        end
    endtask

    task automatic send(input logic [31:0] x, input bit rm);
        bit acc;
        int n;
        acc = 0;
        n = 0;
        while (!acc && n < 1000) begin
            step(1'b1, x, rm, 1'b1, acc);
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept expected accept");
        end
    endtask

    task automatic drain(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 1'b1, acc);
        chk("drain_empty", 32'(q.size()), 32'd0);
        chk("drain_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int sent;
        int k;
        int block_at;
        logic [31:0] xs[8];
        logic [31:0] dir_x[11];
        bit          dir_rm[11];

        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_rm     = 1'b0;
        out_ready = 1'b0;
        #3;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_y", out_y, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        #20;
        rstn = 1'b1;
        #1;
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed conversions with latency checking.
        dir_x  = '{32'd1, 32'hFFFFFFFF, 32'd0, 32'h80000000,
                   32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000001,
                   32'd16777217, 32'd16777219, 32'd16777218, 32'd0};
        dir_rm = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 0};
        lat_chk = 1;
        for (int i = 0; i < 11; i++) send(dir_x[i], dir_rm[i]);
        lat_chk = 0;
        drain(8);
        chk("ref_carry", ref_model(32'h7FFFFFFF, 1'b1), 32'h4F000000);
        chk("ref_tie_up", ref_model(32'd16777219, 1'b1), 32'h4B800002);

        // Back-pressure: output stalled for the first 5 stream cycles.
        for (int i = 0; i < 8; i++) xs[i] = $urandom;
        sent = 0;
        k = 0;
        block_at = -1;
        while (sent < 8 && k < 100) begin
            step(1'b1, xs[sent], 1'b1, (k >= 5), acc);
            if (!acc && block_at < 0) block_at = sent;
            if (k == 5)
                chk("bp_ready_rise", {31'd0, in_ready}, 32'd1);
            if (acc) sent++;
            k++;
        end
        chk("bp_block_after", 32'(block_at), 32'd3);
        chk("bp_sent", 32'(sent), 32'd8);
        drain(8);

        // Reset with a full, stalled pipe.
        for (int i = 0; i < 4; i++)
            step(1'b1, $urandom, 1'b1, 1'b0, acc);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_out_y", out_y, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_in_ready", {31'd0, in_ready}, 32'd0);
        q.delete();
        #17;
        rstn = 1'b1;
        #1;
        chk("mid_rel_ready", {31'd0, in_ready}, 32'd1);
        drain(10);

        // Random traffic with random back-pressure.
        for (int i = 0; i < 10000; i++) begin
            step(($urandom_range(0, 9) < 8), $urandom, $urandom_range(0, 1),
                 ($urandom_range(0, 9) < 7), acc);
        end
        drain(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
